// File: rtl/glitch_sequencer.sv
// glitch_sequencer: after a start strobe or a synchronised ext_trig fall, fires up to NUM_PULSES glitches, each with its own offset and duration.
// First glitch lands offset[0]+1 cycles after the trigger cycle; no backpressure, abort returns to IDLE on the next cycle.
module glitch_sequencer #(
  parameter int NUM_PULSES  = 4,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter bit IDLE_LEVEL  = 1'b1,
  localparam int IDX_W = (NUM_PULSES > 1) ? $clog2(NUM_PULSES) : 1,
  localparam int PC_W  = $clog2(NUM_PULSES) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic             cfg_sel,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [CNT_W-1:0] cfg_data,
  input  logic [PC_W-1:0]  pulse_count,
  input  logic             trig_mode,
  input  logic             arm,
  input  logic             start,
  input  logic             ext_trig,
  input  logic             abort,
  output logic             power_select,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] pulse_idx
);

  localparam int   K_W          = IDX_W + 1;
  localparam logic GLITCH_LEVEL = ~IDLE_LEVEL;

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_OFFSET, S_GLITCH, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_off [NUM_PULSES];
  logic [CNT_W-1:0] r_dur [NUM_PULSES];
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_k;
  logic [K_W-1:0]   r_npulses;
  logic             r_ps;
  logic             r_busy;
  logic             r_done;
  logic             r_sync_d;
  logic             r_trig_edge;

  logic             w_sync;
  logic             w_trig;
  logic [K_W-1:0]   w_pc_clamp;
  logic [K_W-1:0]   w_from;
  logic [K_W-1:0]   w_lim;
  logic             w_found;
  logic [IDX_W-1:0] w_found_idx;
  logic [CNT_W-1:0] w_found_off;
  logic [CNT_W-1:0] w_found_dur;
  state_t           w_go_state;
  logic [CNT_W-1:0] w_go_cnt;
  logic [IDX_W-1:0] w_go_k;
  logic             w_take;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sync <= '1;
        end else begin
          r_sync[0] <= ext_trig;
          for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
      end
      assign w_sync = r_sync[SYNC_STAGES-1];
    end else begin : g_nosync
      assign w_sync = ext_trig;
    end
  endgenerate

  // Registered fall detect puts the trigger cycle SYNC_STAGES+1 after the pin edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_d    <= 1'b1;
      r_trig_edge <= 1'b0;
    end else begin
      r_sync_d    <= w_sync;
      r_trig_edge <= r_sync_d & ~w_sync;
    end
  end

  assign w_trig = trig_mode ? r_trig_edge : start;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PULSES; i++) begin
        r_off[i] <= '0;
        r_dur[i] <= '0;
      end
    end else if (r_state == S_IDLE && cfg_we && 32'(cfg_idx) < NUM_PULSES) begin
      if (cfg_sel) r_dur[cfg_idx] <= cfg_data;
      else         r_off[cfg_idx] <= cfg_data;
    end
  end

  // Next slot with any nonzero time; empty slots take zero cycles and are skipped.
  always_comb begin
    w_pc_clamp = (K_W'(pulse_count) > K_W'(NUM_PULSES)) ? K_W'(NUM_PULSES) : K_W'(pulse_count);
    if (r_state == S_ARMED) begin
      w_from = '0;
      w_lim  = w_pc_clamp;
    end else begin
      w_from = K_W'(r_k) + K_W'(1);
      w_lim  = r_npulses;
    end
    w_found     = 1'b0;
    w_found_idx = '0;
    w_found_off = '0;
    w_found_dur = '0;
    for (int j = NUM_PULSES - 1; j >= 0; j--) begin
      if (K_W'(j) >= w_from && K_W'(j) < w_lim && (r_off[j] != '0 || r_dur[j] != '0)) begin
        w_found     = 1'b1;
        w_found_idx = IDX_W'(j);
        w_found_off = r_off[j];
        w_found_dur = r_dur[j];
      end
    end
    if (!w_found) begin
      w_go_state = S_DONE;
      w_go_cnt   = '0;
      w_go_k     = (r_state == S_ARMED) ? '0 : r_k;
    end else if (w_found_off != '0) begin
      w_go_state = S_OFFSET;
      w_go_cnt   = w_found_off;
      w_go_k     = w_found_idx;
    end else begin
      w_go_state = S_GLITCH;
      w_go_cnt   = w_found_dur;
      w_go_k     = w_found_idx;
    end
    w_take = !abort &&
             ((r_state == S_ARMED  && w_trig) ||
              (r_state == S_OFFSET && r_cnt == CNT_W'(1) && r_dur[r_k] == '0) ||
              (r_state == S_GLITCH && r_cnt == CNT_W'(1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_k       <= '0;
      r_npulses <= '0;
      r_ps      <= IDLE_LEVEL;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
        r_ps    <= IDLE_LEVEL;
        r_busy  <= 1'b0;
      end else if (w_take) begin
        r_state <= w_go_state;
        r_cnt   <= w_go_cnt;
        r_k     <= w_go_k;
        r_ps    <= (w_go_state == S_GLITCH) ? GLITCH_LEVEL : IDLE_LEVEL;
        r_busy  <= (w_go_state != S_DONE);
        r_done  <= (w_go_state == S_DONE);
        if (r_state == S_ARMED) r_npulses <= w_pc_clamp;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (arm) begin
              r_state <= S_ARMED;
              r_busy  <= 1'b1;
            end
          end
          S_ARMED: r_state <= S_ARMED;
          S_OFFSET: begin
            if (r_cnt != CNT_W'(1)) begin
              r_cnt <= r_cnt - CNT_W'(1);
            end else begin
              r_state <= S_GLITCH;
              r_cnt   <= r_dur[r_k];
              r_ps    <= GLITCH_LEVEL;
            end
          end
          S_GLITCH: r_cnt <= r_cnt - CNT_W'(1);
          S_DONE:   r_state <= S_IDLE;
          default:  r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign power_select = r_ps;
  assign busy         = r_busy;
  assign done         = r_done;
  assign pulse_idx    = r_k;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Bench for glitch_sequencer: expected glitch/done events are queued at trigger time and
// popped by a monitor whenever the DUT shows a glitch cycle or a done pulse.
module tb_glitch_sequencer;
  localparam int NP     = 4;
  localparam int CW     = 32;
  localparam int SYNC   = 2;
  localparam int IW     = 2;
  localparam int PW     = 3;
  localparam int NO_CUT = -1;

  logic          clk = 1'b0;
  logic          rst, cfg_we, cfg_sel;
  logic [IW-1:0] cfg_idx;
  logic [CW-1:0] cfg_data;
  logic [PW-1:0] pulse_count;
  logic          trig_mode, arm, start, ext_trig, abort;
  logic          power_select, busy, done;
  logic [IW-1:0] pulse_idx;

  glitch_sequencer #(.NUM_PULSES(NP), .CNT_W(CW), .SYNC_STAGES(SYNC), .IDLE_LEVEL(1'b1)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx),
    .cfg_data(cfg_data), .pulse_count(pulse_count), .trig_mode(trig_mode), .arm(arm),
    .start(start), .ext_trig(ext_trig), .abort(abort), .power_select(power_select),
    .busy(busy), .done(done), .pulse_idx(pulse_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit is_done;
    int idx;
  } evt_t;

  evt_t exp_q[$];
  int   m_off[NP];
  int   m_dur[NP];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: the train is a plain timeline of offset gaps and duration windows.
  task automatic push_model(input int t_trig, input int pc, input int cut_rel);
    int   n, t, cut;
    evt_t e;
    cut = (cut_rel < 0) ? 32'h7fff_ffff : t_trig + cut_rel;
    n = (pc > NP) ? NP : pc;
    t = t_trig + 1;
    for (int k = 0; k < n; k++) begin
      t += m_off[k];
      for (int d = 0; d < m_dur[k]; d++) begin
        if (t + d <= cut) begin
          e.cyc = t + d; e.is_done = 1'b0; e.idx = k;
          exp_q.push_back(e);
        end
      end
      t += m_dur[k];
    end
    if (t <= cut) begin
      e.cyc = t; e.is_done = 1'b1; e.idx = 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic take_event(input bit is_done);
    evt_t e;
    check("event_expected", exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("event_cycle", cyc, e.cyc);
      check("event_kind", is_done, e.is_done);
      if (is_done) begin
        check("busy_at_done", busy, 1'b0);
      end else begin
        check("pulse_idx", pulse_idx, e.idx);
        check("busy_in_glitch", busy, 1'b1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (power_select === 1'b0) take_event(1'b0);
    if (done === 1'b1)         take_event(1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input bit sel, input int idx, input int val, input bit model_upd);
    cfg_we = 1'b1; cfg_sel = sel; cfg_idx = IW'(idx); cfg_data = CW'(val);
    tick();
    cfg_we = 1'b0;
    if (model_upd) begin
      if (sel) m_dur[idx] = val;
      else     m_off[idx] = val;
    end
  endtask

  task automatic set_slot(input int idx, input int off, input int dur);
    cfg_write(1'b0, idx, off, 1'b1);
    cfg_write(1'b1, idx, dur, 1'b1);
  endtask

  task automatic arm_trigger(input bit mode, input int pc, input int gap, input bit arm_with_start,
                             input int cut_rel, output int t_trig);
    trig_mode = mode; pulse_count = PW'(pc);
    arm = 1'b1; start = arm_with_start;
    tick();
    arm = 1'b0; start = 1'b0;
    check("busy_after_arm", busy, 1'b1);
    repeat (gap) tick();
    if (!mode) begin
      start  = 1'b1;
      t_trig = cyc;
      push_model(t_trig, pc, cut_rel);
      tick();
      start = 1'b0;
    end else begin
      start = 1'b1;
      tick();
      start    = 1'b0;
      ext_trig = 1'b0;
      t_trig   = cyc + SYNC + 1;
      push_model(t_trig, pc, cut_rel);
      tick();
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
    check(name, exp_q.size(), 0);
    repeat (3) tick();
    ext_trig = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_idx = '0; cfg_data = '0;
    pulse_count = '0; trig_mode = 1'b0; arm = 1'b0; start = 1'b0; ext_trig = 1'b1; abort = 1'b0;
    repeat (3) tick();
    check("rst_power_select", power_select, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pulse_idx", pulse_idx, 0);
    rst = 1'b0;
    tick();

    set_slot(0, 10, 3);
    arm_trigger(1'b0, 1, 1, 1'b0, NO_CUT, t);
    drain("drain_single");

    set_slot(0, 5, 2); set_slot(1, 0, 1); set_slot(2, 4, 3);
    arm_trigger(1'b0, 3, 0, 1'b0, NO_CUT, t);
    drain("drain_three");

    set_slot(0, 3, 2); set_slot(1, 2, 0);
    arm_trigger(1'b0, 2, 2, 1'b0, NO_CUT, t);
    drain("drain_zero_dur");

    arm_trigger(1'b0, 0, 1, 1'b0, NO_CUT, t);
    drain("drain_zero_count");

    set_slot(0, 0, 1);
    arm_trigger(1'b1, 1, 1, 1'b0, NO_CUT, t);
    drain("drain_ext_trig");

    set_slot(0, 1, 2);
    arm_trigger(1'b0, 1, 3, 1'b1, NO_CUT, t);
    drain("drain_arm_start");

    // Abort on the 20th glitch cycle of a 100-cycle window.
    set_slot(0, 2, 100);
    arm_trigger(1'b0, 1, 0, 1'b0, 22, t);
    while (cyc < t + 22) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_power_select", power_select, 1'b1);
    check("abort_busy", busy, 1'b0);
    repeat (110) tick();
    drain("drain_abort");
    set_slot(0, 2, 4);
    arm_trigger(1'b0, 1, 0, 1'b0, NO_CUT, t);
    drain("drain_rearm");

    set_slot(0, 8, 2);
    arm_trigger(1'b0, 1, 0, 1'b0, NO_CUT, t);
    tick();
    cfg_write(1'b0, 0, 1, 1'b0);
    cfg_write(1'b1, 0, 7, 1'b0);
    drain("drain_cfg_locked");
    arm_trigger(1'b0, 1, 1, 1'b0, NO_CUT, t);
    drain("drain_cfg_kept");

    set_slot(0, 5, 2); set_slot(1, 0, 1); set_slot(2, 4, 3);
    arm_trigger(1'b0, 3, 0, 1'b0, 7, t);
    while (cyc < t + 7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_power_select", power_select, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_pulse_idx", pulse_idx, 0);
    for (int k = 0; k < NP; k++) begin
      m_off[k] = 0;
      m_dur[k] = 0;
    end
    drain("drain_midrst");
    arm_trigger(1'b0, 4, 1, 1'b0, NO_CUT, t);
    drain("drain_after_rst");

    for (int it = 0; it < 30; it++) begin
      for (int k = 0; k < NP; k++) set_slot(k, $urandom_range(0, 6), $urandom_range(0, 4));
      arm_trigger($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 3),
                  1'b0, NO_CUT, t);
      drain("drain_random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/glitch_sequencer.md
Name: glitch_sequencer

Overview:
- Parametrised successor to the single-shot offset/duration counter pair in the iCEstick glitcher.
- Generates a train of up to NUM_PULSES glitch pulses on power_select after a trigger event. Each pulse has its own programmable offset (gap) and duration.
- Trigger is either the command processor's start strobe or a synchronised edge on an external pin, e.g. target UART activity.
- Sits between command_processor and the external MOSFET drive; takes over from offset_counter/duration_counter.

Parameters:
- NUM_PULSES, 4, number of pulse slots (1..16).
- CNT_W, 32, width of offset and duration counters.
- SYNC_STAGES, 2, synchroniser depth on ext_trig (0 = bypass, input already synchronous).
- IDLE_LEVEL, 1, power_select level when not glitching; the glitch level is the inverse.

Ports:
- clk  in  1  system clock (100 MHz PLL output).
- rst  in  1  synchronous active-high reset.
- cfg_we  in  1  config write strobe.
- cfg_sel  in  1  0 = write offset, 1 = write duration.
- cfg_idx  in  $clog2(NUM_PULSES)  pulse slot addressed.
- cfg_data  in  CNT_W  value written.
- pulse_count  in  $clog2(NUM_PULSES)+1  pulses to fire; sampled at trigger.
- trig_mode  in  1  0 = start strobe, 1 = ext_trig falling edge.
- arm  in  1  one-cycle strobe: enter ARMED.
- start  in  1  one-cycle trigger strobe (mode 0).
- ext_trig  in  1  asynchronous trigger pin (mode 1).
- abort  in  1  one-cycle strobe: cancel sequence (driven by target reset request).
- power_select  out  1  glitch output, registered.
- busy  out  1  high in ARMED/OFFSET/GLITCH.
- done  out  1  one-cycle pulse when the sequence completes.
- pulse_idx  out  $clog2(NUM_PULSES)  slot currently being timed.

Behaviour:
- Reset values: power_select=IDLE_LEVEL, busy=0, done=0, pulse_idx=0, state=IDLE. All offset/duration registers = 0. The synchroniser flops reset to 1.
- Configuration:
  - Config writes are accepted only in IDLE; writes in any other state are ignored.
  - A write takes effect the next cycle.
  - cfg_idx >= NUM_PULSES is ignored.
- States: IDLE, ARMED, OFFSET, GLITCH, DONE.
- IDLE:
  - arm=1 -> ARMED.
  - start and ext_trig are ignored in IDLE.
- ARMED:
  - A trigger event moves to OFFSET, loads slot 0, and latches pulse_count into n_pulses.
  - Trigger event: start=1 (mode 0), or synchronised ext_trig high-to-low (mode 1).
  - If the latched n_pulses is 0 -> DONE directly; no glitch is produced.
  - n_pulses > NUM_PULSES is clamped to NUM_PULSES.
- Timing for slot k, with the trigger event in cycle T:
  - power_select goes to the glitch level at cycle T+1+offset[0] and stays there exactly duration[0] cycles.
  - Slot k+1 glitch begins offset[k+1] cycles after slot k's glitch ends.
  - offset=0 means the glitch starts in the cycle immediately following the trigger, or back-to-back with the previous pulse.
- OFFSET: the down-counter is loaded with offset[k] and counts to 0, then -> GLITCH.
- GLITCH:
  - The counter is loaded with duration[k]; power_select is at the glitch level while the counter is nonzero.
  - duration=0: the slot produces no glitch cycle, but its offset still elapses.
- Slot advance: when the slot ends, k+1 < n_pulses -> OFFSET with k+1; otherwise -> DONE.
- DONE: done=1 for one cycle, power_select=IDLE_LEVEL, then -> IDLE.
- pulse_idx = current k and holds its value through DONE.
- busy is asserted the cycle after arm is accepted. It deasserts in the same cycle done pulses.
- Synchroniser latency: in mode 1, the edge is detected SYNC_STAGES+1 cycles after the pin transition. T is defined as the detection cycle.
- Abort:
  - abort=1 in any state: next cycle -> IDLE, power_select=IDLE_LEVEL, busy=0, no done pulse.
  - Abort has priority over a simultaneous trigger, arm, or slot advance.
  - rst has priority over everything.
- Simultaneous arm+start in IDLE: only arm is taken. The start is not remembered.
- Counters are CNT_W bits wide and never wrap: the maximum value 2^CNT_W-1 gives exactly that many cycles.

Test Plan:
- Single pulse, mode 0: offset[0]=10, duration[0]=3, pulse_count=1, arm, start at T -> power_select low at T+11..T+13, done at T+14, busy then 0.
- Three-pulse train: offsets {5,0,4}, durations {2,1,3}, start at T -> glitch cycles T+6..T+7, T+8, T+13..T+15. pulse_idx steps 0,1,2.
- Edge cases: duration[1]=0 in a 2-pulse train -> only one glitch window, done still fires. pulse_count=0 -> done one cycle after trigger, no glitch.
- Mode 1: ext_trig falls at pin cycle P with SYNC_STAGES=2, offset=0, duration=1 -> glitch at P+4. A start strobe in mode 1 is ignored.
- Abort mid-GLITCH: duration=100, abort at cycle 20 of the glitch -> power_select=1 next cycle, busy=0, done never pulses. A re-arm works normally.
- Config write during OFFSET changes nothing in the running train. rst mid-train -> all outputs at reset values next cycle.
